// File: rtl/pwm_peripheral_if.sv
// -----------------------------------------------------------------------------
// pwm_peripheral_if
// Groups the register-side inputs and the chip-side outputs of the PWM
// peripheral into one bundle.
//   master : drives the five configuration registers, observes the outputs
//   slave  : the PWM peripheral itself
// Signals:
//   en_reg_out_7_0 / en_reg_out_15_8  output enables, outputs 7..0 / 15..8
//   en_reg_pwm_7_0 / en_reg_pwm_15_8  PWM mode select, outputs 7..0 / 15..8
//   pwm_duty_cycle                    shared 8-bit duty cycle
//   out                               16 chip outputs
//   period_start                      one-clk pulse at each PWM period start
// -----------------------------------------------------------------------------
interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
// Drives 16 chip outputs from the SPI-written configuration registers. Each
// output is forced low, driven static high, or driven with one shared PWM
// waveform. All PWM outputs share a single free-running phase.
//
// Parameters:
//   CLK_DIV : clk cycles per PWM tick (1..65535); one period = 256*CLK_DIV clks
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : pwm_peripheral_if.slave (register inputs, out, period_start)
// Build option:
//   PWM_SYNC_UPDATE_EN : when defined, the duty cycle is taken from a shadow
//   register that only loads on the tick wrapping the period counter, so duty
//   changes take effect at the next period start. When undefined the duty
//   input is compared live.
// -----------------------------------------------------------------------------
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 32'd13
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_peripheral_if.slave   bus
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 32'd1);

    logic [15:0] div_cnt_q;
    logic [15:0] div_cnt_d;
    logic [7:0]  pwm_cnt_q;
    logic [7:0]  pwm_cnt_d;
    logic        period_start_q;
    logic        period_start_d;
    logic [15:0] out_q;
    logic [15:0] out_d;

    logic        tick_s;
    logic        wrap_s;
    logic [7:0]  duty_s;
    logic        level_s;
    logic [15:0] en_out_s;
    logic [15:0] en_pwm_s;

    assign en_out_s = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm_s = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // Prescaler and period counter next state; wrap_s marks the tick taking 255->0.
    always_comb begin
        div_cnt_d      = div_cnt_q;
        pwm_cnt_d      = pwm_cnt_q;
        tick_s         = (div_cnt_q == DIV_LAST);
        wrap_s         = tick_s && (pwm_cnt_q == 8'hFF);
        period_start_d = wrap_s;
        if (tick_s) begin
            div_cnt_d = 16'd0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
        end
    end

`ifdef PWM_SYNC_UPDATE_EN
    logic [7:0] duty_q;
    logic [7:0] duty_d;

    // Shadow duty loads only on the wrap tick, so a period never sees a mid-period write.
    always_comb begin
        if (wrap_s) begin
            duty_d = bus.pwm_duty_cycle;
        end else begin
            duty_d = duty_q;
        end
    end

    // Shadow duty register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= 8'h00;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_s = duty_q;
`else
    assign duty_s = bus.pwm_duty_cycle;
`endif

    // PWM level: 0xFF is a true 100% (no low at count 255), 0x00 is constant low.
    always_comb begin
        case (duty_s)
            8'hFF:   level_s = 1'b1;
            8'h00:   level_s = 1'b0;
            default: level_s = (pwm_cnt_q < duty_s);
        endcase
    end

    // Per-output select: disabled -> 0, enabled static -> 1, enabled PWM -> level.
    always_comb begin
        out_d = en_out_s & (~en_pwm_s | {16{level_s}});
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q      <= 16'd0;
            pwm_cnt_q      <= 8'd0;
            period_start_q <= 1'b0;
            out_q          <= 16'h0000;
        end else begin
            div_cnt_q      <= div_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
            out_q          <= out_d;
        end
    end

    assign bus.out          = out_q;
    assign bus.period_start = period_start_q;

endmodule
